recog_frame_sequencer: RTL and testbench



---
 rtl/recog_pkg.sv | 45 ++++
 rtl/vs_edge_detect.sv | 49 ++++
 rtl/recog_frame_sequencer.sv | 137 +++++++++++++
 tb/tb_recog_frame_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/recog_pkg.sv
// Shared constants for the digit-recognition frame sequencer.
//   - Phase codes driven on frame_cnt and decoded by the bounding-box and
//     feature-extraction datapath.
//   - Bit layout of the packed feature result word.
package recog_pkg;

  localparam logic [2:0] PH_IDLE   = 3'd7;
  localparam logic [2:0] PH_BBOX   = 3'd1;
  localparam logic [2:0] PH_SETTLE = 3'd2;
  localparam logic [2:0] PH_SCAN   = 3'd3;
  localparam logic [2:0] PH_READ   = 3'd0;

  localparam int FEAT_W       = 16;
  localparam int FEAT_CNT_W   = 4;
  localparam int FEAT_Y_LSB   = 12;
  localparam int FEAT_X2_LSB  = 8;
  localparam int FEAT_X1_LSB  = 4;
  localparam int FEAT_X1L_BIT = 3;
  localparam int FEAT_X1R_BIT = 2;
  localparam int FEAT_X2L_BIT = 1;
  localparam int FEAT_X2R_BIT = 0;

  // Packs {y, x2, x1, x1_l, x1_r, x2_l, x2_r} into one result word.
  function automatic logic [FEAT_W-1:0] pack_feat(
    input logic [FEAT_CNT_W-1:0] y,
    input logic [FEAT_CNT_W-1:0] x2,
    input logic [FEAT_CNT_W-1:0] x1,
    input logic                  x1_l,
    input logic                  x1_r,
    input logic                  x2_l,
    input logic                  x2_r
  );
    logic [FEAT_W-1:0] w;
    w = '0;
    w[FEAT_Y_LSB  +: FEAT_CNT_W] = y;
    w[FEAT_X2_LSB +: FEAT_CNT_W] = x2;
    w[FEAT_X1_LSB +: FEAT_CNT_W] = x1;
    w[FEAT_X1L_BIT] = x1_l;
    w[FEAT_X1R_BIT] = x1_r;
    w[FEAT_X2L_BIT] = x2_l;
    w[FEAT_X2R_BIT] = x2_r;
    return w;
  endfunction

endpackage

// File: rtl/vs_edge_detect.sv
// Two-flop input pipeline with edge detection for a slow frame-level strobe.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   sig           : raw input strobe
//   det_r, det_f  : combinational rise/fall detects (one cycle ahead of pulses)
//   rise, fall    : registered one-cycle edge pulses
//   sig_o         : input delayed to line up with rise/fall
module vs_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic det_r,
  output logic det_f,
  output logic rise,
  output logic fall,
  output logic sig_o
);

  logic s0;
  logic s1;
  logic sampled;
  logic armed;

  // A rise only counts once the input has been seen low after reset, so a
  // strobe already high when reset releases does not look like a new edge.
  assign det_r = s0 & ~s1 & armed;
  assign det_f = ~s0 & s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0      <= 1'b0;
      s1      <= 1'b0;
      sampled <= 1'b0;
      armed   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      sig_o   <= 1'b0;
    end else begin
      s0      <= sig;
      s1      <= s0;
      sampled <= 1'b1;
      armed   <= armed | (sampled & ~s0);
      rise    <= det_r;
      fall    <= det_f;
      sig_o   <= s0;
    end
  end

endmodule

// File: rtl/recog_frame_sequencer.sv
// Frame-level controller for the digit-recognition pipeline.
// Ports:
//   clk, rst                 : pixel clock, synchronous active-high reset
//   enable                   : run request, sampled at each detected frame_vs rise
//   frame_vs                 : raw frame-active strobe
//   hcount_l/r, vcount_l/r   : bounding box from the box detector
//   x1, x2, y, x1_l..x2_r    : feature counters and side flags
//   frame_vs_o               : frame_vs aligned with the edge pulses
//   frame_vs_rise/fall       : one-cycle edge pulses
//   frame_cnt                : phase code (7 idle, 1 bbox, 2 settle, 3 scan, 0 read)
//   feat, feat_valid         : captured result word and its strobe
//   bbox_err, timeout        : one-cycle error pulses
//   err_cnt                  : saturating error event count
module recog_frame_sequencer
  import recog_pkg::*;
#(
  parameter int unsigned MIN_SPAN   = 8,
  parameter int unsigned VS_TIMEOUT = 2_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              frame_vs,
  input  logic [10:0]       hcount_l,
  input  logic [10:0]       hcount_r,
  input  logic [10:0]       vcount_l,
  input  logic [10:0]       vcount_r,
  input  logic [3:0]        x1,
  input  logic [3:0]        x2,
  input  logic [3:0]        y,
  input  logic              x1_l,
  input  logic              x1_r,
  input  logic              x2_l,
  input  logic              x2_r,
  output logic              frame_vs_o,
  output logic              frame_vs_rise,
  output logic              frame_vs_fall,
  output logic [2:0]        frame_cnt,
  output logic [FEAT_W-1:0] feat,
  output logic              feat_valid,
  output logic              bbox_err,
  output logic              timeout,
  output logic [7:0]        err_cnt
);

  localparam int WD_W = 21;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic            det_r;
  logic            det_f;
  logic [WD_W-1:0] wd;
  logic            wd_expire;
  logic            box_ok;
  logic            bad_box;
  logic            capture;
  logic [2:0]      ph_nxt;

  vs_edge_detect u_vs_edge (
    .clk   (clk),
    .rst   (rst),
    .sig   (frame_vs),
    .det_r (det_r),
    .det_f (det_f),
    .rise  (frame_vs_rise),
    .fall  (frame_vs_fall),
    .sig_o (frame_vs_o)
  );

  // Widened to 12 bits so the left edge plus span cannot wrap past 2047.
  assign box_ok = ({1'b0, hcount_r} >= ({1'b0, hcount_l} + 12'(MIN_SPAN))) &&
                  ({1'b0, vcount_r} >= ({1'b0, vcount_l} + 12'(MIN_SPAN)));

  // A frame rise in the same cycle takes priority and suppresses expiry.
  assign wd_expire = (wd == WD_W'(VS_TIMEOUT - 1)) && !det_r && (frame_cnt != PH_IDLE);

  assign capture = det_f && (frame_cnt == PH_READ);

  always_comb begin
    ph_nxt  = frame_cnt;
    bad_box = 1'b0;
    if (det_r) begin
      if (!enable) begin
        ph_nxt = PH_IDLE;
      end else begin
        case (frame_cnt)
          PH_IDLE:   ph_nxt = PH_BBOX;
          PH_BBOX:   ph_nxt = PH_SETTLE;
          PH_SETTLE: begin
            if (box_ok) begin
              ph_nxt = PH_SCAN;
            end else begin
              ph_nxt  = PH_BBOX;
              bad_box = 1'b1;
            end
          end
          PH_SCAN:   ph_nxt = PH_READ;
          PH_READ:   ph_nxt = PH_BBOX;
          default:   ph_nxt = PH_IDLE;
        endcase
      end
    end else if (wd_expire) begin
      ph_nxt = PH_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt  <= PH_IDLE;
      wd         <= '0;
      bbox_err   <= 1'b0;
      timeout    <= 1'b0;
      err_cnt    <= 8'd0;
      feat       <= '0;
      feat_valid <= 1'b0;
    end else begin
      frame_cnt  <= ph_nxt;
      bbox_err   <= bad_box;
      timeout    <= wd_expire;
      feat_valid <= capture;
      if (bad_box || wd_expire) begin
        err_cnt <= sat_inc(err_cnt);
      end
      if (det_r || wd_expire || (frame_cnt == PH_IDLE)) begin
        wd <= '0;
      end else begin
        wd <= wd + 1'b1;
      end
      if (capture) begin
        feat <= pack_feat(y, x2, x1, x1_l, x1_r, x2_l, x2_r);
      end
    end
  end

endmodule

// File: tb/tb_recog_frame_sequencer.sv
// Directed bench for recog_frame_sequencer (MIN_SPAN 8, VS_TIMEOUT 100).
module tb_recog_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        frame_vs;
  logic [10:0] hcount_l, hcount_r, vcount_l, vcount_r;
  logic [3:0]  x1, x2, y;
  logic        x1_l, x1_r, x2_l, x2_r;
  logic        frame_vs_o, frame_vs_rise, frame_vs_fall;
  logic [2:0]  frame_cnt;
  logic [15:0] feat;
  logic        feat_valid, bbox_err, timeout;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  recog_frame_sequencer #(.MIN_SPAN(8), .VS_TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_vs(frame_vs),
    .hcount_l(hcount_l), .hcount_r(hcount_r),
    .vcount_l(vcount_l), .vcount_r(vcount_r),
    .x1(x1), .x2(x2), .y(y),
    .x1_l(x1_l), .x1_r(x1_r), .x2_l(x2_l), .x2_r(x2_r),
    .frame_vs_o(frame_vs_o), .frame_vs_rise(frame_vs_rise),
    .frame_vs_fall(frame_vs_fall), .frame_cnt(frame_cnt),
    .feat(feat), .feat_valid(feat_valid), .bbox_err(bbox_err),
    .timeout(timeout), .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise frame_vs; pulse and new phase must appear on the second edge.
  task automatic rise_to(input logic [2:0] ph, input logic eb, input string tag);
    frame_vs = 1'b1;
    step();
    chk({tag, "_pre"}, frame_vs_rise, 0);
    step();
    chk({tag, "_rise"}, frame_vs_rise, 1);
    chk({tag, "_ph"}, frame_cnt, ph);
    chk({tag, "_vso"}, frame_vs_o, 1);
    chk({tag, "_berr"}, bbox_err, eb);
    step();
    chk({tag, "_rise1"}, frame_vs_rise, 0);
    chk({tag, "_berr1"}, bbox_err, 0);
    repeat (5) step();
  endtask

  task automatic fall_chk(input logic fv, input string tag);
    frame_vs = 1'b0;
    step();
    step();
    chk({tag, "_fall"}, frame_vs_fall, 1);
    chk({tag, "_fv"}, feat_valid, fv);
    step();
    chk({tag, "_fv1"}, feat_valid, 0);
    repeat (5) step();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ph"}, frame_cnt, 7);
    chk({tag, "_feat"}, feat, 0);
    chk({tag, "_err"}, err_cnt, 0);
    chk({tag, "_fv"}, feat_valid, 0);
    chk({tag, "_rise"}, frame_vs_rise, 0);
    chk({tag, "_fall"}, frame_vs_fall, 0);
    chk({tag, "_vso"}, frame_vs_o, 0);
    chk({tag, "_berr"}, bbox_err, 0);
    chk({tag, "_to"}, timeout, 0);
  endtask

  initial begin
    int  n;
    logic seen;
    rst = 1'b1; enable = 1'b0; frame_vs = 1'b0;
    hcount_l = 11'd10; hcount_r = 11'd100; vcount_l = 11'd20; vcount_r = 11'd200;
    x1 = 4'd2; x2 = 4'd1; y = 4'd3;
    x1_l = 1'b0; x1_r = 1'b0; x2_l = 1'b0; x2_r = 1'b1;
    step(); step();
    chk_reset("rst0");
    rst = 1'b0;
    repeat (3) step();

    // Nominal four-frame cycle with capture on the READ fall.
    enable = 1'b1;
    rise_to(3'd1, 1'b0, "f1"); fall_chk(1'b0, "f1");
    rise_to(3'd2, 1'b0, "f2"); fall_chk(1'b0, "f2");
    rise_to(3'd3, 1'b0, "f3"); fall_chk(1'b0, "f3");
    rise_to(3'd0, 1'b0, "f4"); fall_chk(1'b1, "f4");
    chk("feat_3121", feat, 16'h3121);

    // Box only 5 wide at the rise out of SETTLE.
    rise_to(3'd1, 1'b0, "f5"); fall_chk(1'b0, "f5");
    rise_to(3'd2, 1'b0, "f6"); fall_chk(1'b0, "f6");
    hcount_r = 11'd15;
    rise_to(3'd1, 1'b1, "badbox");
    chk("err_cnt1", err_cnt, 1);
    fall_chk(1'b0, "badbox");

    // Width exactly MIN_SPAN is accepted; enable drops during SCAN.
    rise_to(3'd2, 1'b0, "f8"); fall_chk(1'b0, "f8");
    hcount_r = 11'd18;
    rise_to(3'd3, 1'b0, "span8");
    chk("feat_hold", feat, 16'h3121);
    enable = 1'b0;
    fall_chk(1'b0, "scan_noen");
    rise_to(3'd7, 1'b0, "noen");
    fall_chk(1'b0, "noen");

    // Watchdog: enter BBOX then hold frame_vs low.
    enable = 1'b1;
    frame_vs = 1'b1;
    step(); step();
    chk("wd_ph", frame_cnt, 1);
    frame_vs = 1'b0;
    n = 0;
    while (n < 200) begin
      step();
      n++;
      if (timeout) break;
    end
    chk("wd_cycles", n, 100);
    chk("wd_ph_idle", frame_cnt, 7);
    chk("wd_err", err_cnt, 2);
    step();
    chk("wd_to1", timeout, 0);
    repeat (3) step();

    // One-cycle glitch on frame_vs.
    frame_vs = 1'b1;
    step();
    frame_vs = 1'b0;
    step();
    chk("gl_rise", frame_vs_rise, 1);
    chk("gl_ph", frame_cnt, 1);
    step();
    chk("gl_fall", frame_vs_fall, 1);
    chk("gl_rise0", frame_vs_rise, 0);
    repeat (5) step();

    // Second capture with both x1_l and x2_r set.
    x1_l = 1'b1;
    rise_to(3'd2, 1'b0, "c2"); fall_chk(1'b0, "c2");
    rise_to(3'd3, 1'b0, "c3"); fall_chk(1'b0, "c3");
    rise_to(3'd0, 1'b0, "c0"); fall_chk(1'b1, "c0");
    chk("feat_3129", feat, 16'h3129);

    // Reset while in READ with frame_vs high.
    rise_to(3'd1, 1'b0, "r1"); fall_chk(1'b0, "r1");
    rise_to(3'd2, 1'b0, "r2"); fall_chk(1'b0, "r2");
    rise_to(3'd3, 1'b0, "r3"); fall_chk(1'b0, "r3");
    rise_to(3'd0, 1'b0, "r0");
    rst = 1'b1;
    step();
    chk_reset("rst1");
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      step();
      if (frame_vs_rise) seen = 1'b1;
    end
    chk("rst_norise", seen, 0);
    chk("rst_idle", frame_cnt, 7);
    frame_vs = 1'b0;
    repeat (3) step();
    frame_vs = 1'b1;
    step(); step();
    chk("rst_rise", frame_vs_rise, 1);
    chk("rst_ph", frame_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
